// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the D-cache controller
// (requester 0) and the I-cache refill engine (requester 1).
module dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_burst,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_done,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_burst,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_done,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_last_winner;
    logic              r_we;
    logic              r_burst;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_take;
    logic              w_win;
    logic              w_last;
    logic              w_sel_we;
    logic              w_sel_burst;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_gnt;
    logic [1:0]        w_rvalid;
    logic [1:0]        w_done;

    assign w_sel_we    = w_win ? r1_we    : r0_we;
    assign w_sel_burst = (w_win ? r1_burst : r0_burst) & ~w_sel_we;
    assign w_sel_addr  = w_win ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_win ? r1_wdata : r0_wdata;
    assign w_last      = r_we | ~r_burst | (r_cnt == LAST_CNT);

    // Nothing is driven while reset is asserted, so an in-flight
    // transfer can never report completion during the reset cycle.
    always_comb begin
        w_next    = r_state;
        w_take    = 1'b0;
        w_win     = 1'b0;
        w_gnt     = 2'b00;
        w_rvalid  = 2'b00;
        w_done    = 2'b00;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        w_take       = 1'b1;
                        w_win        = (r0_req && r1_req) ? ~r_last_winner : r1_req;
                        w_gnt[w_win] = 1'b1;
                        w_next       = ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_en = r_we;
                    mem_rd_en = ~r_we;
                    mem_addr  = r_base + ADDR_W'(r_cnt);
                    mem_wdata = r_wdata;
                    if (mem_done) begin
                        w_rvalid[r_owner] = ~r_we;
                        if (w_last) begin
                            w_done[r_owner] = 1'b1;
                            w_next          = IDLE;
                        end
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_winner <= 1'b1;
            r_we          <= 1'b0;
            r_burst       <= 1'b0;
            r_base        <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_owner       <= w_win;
                r_last_winner <= w_win;
                r_we          <= w_sel_we;
                r_burst       <= w_sel_burst;
                r_base        <= w_sel_burst ? (w_sel_addr & ~BLK_MASK) : w_sel_addr;
                r_wdata       <= w_sel_wdata;
                r_cnt         <= '0;
            end else if (r_state == ACCESS && mem_done && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];
    assign r0_rvalid = w_rvalid[0];
    assign r1_rvalid = w_rvalid[1];
    assign r0_done   = w_done[0];
    assign r1_done   = w_done[1];
    assign r0_rdata  = w_rvalid[0] ? mem_rdata : '0;
    assign r1_rdata  = w_rvalid[1] ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus randomized traffic for dmem_arbiter, checked
// against a transaction-level model of arbitration and word sequencing.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, burst;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  gnt, rvalid, done;
    logic [31:0] rdata [2];
    logic        mem_rd_en, mem_wr_en, mem_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BLOCK_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(req[0]), .r0_we(we[0]), .r0_burst(burst[0]),
        .r0_addr(addr[0]), .r0_wdata(wdata[0]),
        .r0_gnt(gnt[0]), .r0_rvalid(rvalid[0]),
        .r0_rdata(rdata[0]), .r0_done(done[0]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_burst(burst[1]),
        .r1_addr(addr[1]), .r1_wdata(wdata[1]),
        .r1_gnt(gnt[1]), .r1_rvalid(rvalid[1]),
        .r1_rdata(rdata[1]), .r1_done(done[1]),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'd0);
        check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_en"}, 64'({mem_rd_en, mem_wr_en}), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_rd0"}, 64'(rdata[0]), 64'd0);
        check({tag, "_rd1"}, 64'(rdata[1]), 64'd0);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        req = 2'b00;
        mem_done = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check_quiet("reset");
    endtask

    task automatic set_req(input int n, input logic w, input logic b,
                           input logic [31:0] a, input logic [31:0] d);
        req[n]   = 1'b1;
        we[n]    = w;
        burst[n] = b;
        addr[n]  = a;
        wdata[n] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int          m_busy;
    int          m_own;
    int          m_last;
    int          w;
    logic        m_we;
    logic [31:0] m_wd;
    logic [31:0] m_q[$];
    logic [1:0]  m_fin;
    logic [1:0]  e_gnt, e_rv, e_dn;
    logic [31:0] e_rd [2];
    logic [31:0] base;

    initial begin
        rst = 1'b1;
        req = 2'b00; we = 2'b00; burst = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        mem_done = 1'b0; mem_rdata = '0;
        do_reset();

        // single read, zero-wait memory
        cyc();
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        check("d1_gnt0", 64'(gnt[0]), 64'd1);
        check("d1_gnt1", 64'(gnt[1]), 64'd0);
        check("d1_rden_T", 64'(mem_rd_en), 64'd0);
        cyc();
        mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("d1_rden", 64'(mem_rd_en), 64'd1);
        check("d1_addr", 64'(mem_addr), 64'h10);
        check("d1_rv0", 64'(rvalid[0]), 64'd1);
        check("d1_rd0", 64'(rdata[0]), 64'hDEAD_BEEF);
        check("d1_done0", 64'(done[0]), 64'd1);
        check("d1_r1", 64'({gnt[1], rvalid[1], done[1]}), 64'd0);
        check("d1_rd1", 64'(rdata[1]), 64'd0);
        cyc();
        req[0] = 1'b0; mem_done = 1'b0;
        #1;
        check_quiet("d1_after");

        // burst read from requester 1, unaligned address
        cyc();
        set_req(1, 1'b0, 1'b1, 32'h23, 32'h0);
        #1;
        check("d2_gnt1", 64'(gnt[1]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_done = 1'b1; mem_rdata = memf(32'h20 + i);
            #1;
            check("d2_addr", 64'(mem_addr), 64'(32'h20 + i));
            check("d2_rv1", 64'(rvalid[1]), 64'd1);
            check("d2_rd1", 64'(rdata[1]), 64'(memf(32'h20 + i)));
            check("d2_done1", 64'(done[1]), 64'(i == 3));
            check("d2_r0", 64'({rvalid[0], done[0]}), 64'd0);
        end
        cyc();
        req[1] = 1'b0; mem_done = 1'b0;
        #1;
        check_quiet("d2_after");

        // simultaneous writes after reset, two wait cycles each
        do_reset();
        cyc();
        set_req(0, 1'b1, 1'b0, 32'h100, 32'hAAAA_0000);
        set_req(1, 1'b1, 1'b0, 32'h200, 32'hBBBB_0000);
        #1;
        check("d3_gnt", 64'(gnt), 64'b01);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            mem_done = (k == 3);
            #1;
            check("d3_wr0", 64'({mem_wr_en, mem_rd_en}), 64'b10);
            check("d3_addr0", 64'(mem_addr), 64'h100);
            check("d3_wd0", 64'(mem_wdata), 64'hAAAA_0000);
            check("d3_done0", 64'(done), (k == 3) ? 64'b01 : 64'b00);
            check("d3_rv", 64'(rvalid), 64'd0);
        end
        cyc();
        req[0] = 1'b0; mem_done = 1'b0;
        #1;
        check("d3_gnt_b", 64'(gnt), 64'b10);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            mem_done = (k == 3);
            #1;
            check("d3_addr1", 64'(mem_addr), 64'h200);
            check("d3_wd1", 64'(mem_wdata), 64'hBBBB_0000);
            check("d3_done1", 64'(done), (k == 3) ? 64'b10 : 64'b00);
        end
        cyc();
        req[0] = 1'b1; mem_done = 1'b0;
        #1;
        check("d3_gnt_c", 64'(gnt), 64'b01);
        do_reset();

        // write held off by five memory cycles
        cyc();
        set_req(0, 1'b1, 1'b0, 32'h44, 32'h1234_5678);
        #1;
        check("d4_gnt0", 64'(gnt), 64'b01);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            mem_done = (k == 5);
            #1;
            check("d4_en", 64'({mem_wr_en, mem_rd_en}), 64'b10);
            check("d4_addr", 64'(mem_addr), 64'h44);
            check("d4_wdata", 64'(mem_wdata), 64'h1234_5678);
            check("d4_rv", 64'(rvalid), 64'd0);
            check("d4_done", 64'(done), (k == 5) ? 64'b01 : 64'b00);
        end
        cyc();
        req[0] = 1'b0; mem_done = 1'b0;
        #1;
        check_quiet("d4_after");

        // reset in the middle of a burst
        cyc();
        set_req(0, 1'b0, 1'b1, 32'h31, 32'h0);
        #1;
        check("d5_gnt", 64'(gnt), 64'b01);
        for (int i = 0; i < 2; i++) begin
            cyc();
            mem_done = 1'b1; mem_rdata = memf(32'h30 + i);
            #1;
            check("d5_addr", 64'(mem_addr), 64'(32'h30 + i));
            check("d5_rv", 64'(rvalid), 64'b01);
        end
        cyc();
        rst = 1'b1; req[0] = 1'b0; mem_done = 1'b1;
        #1;
        check("d5_done_in_rst", 64'(done), 64'd0);
        cyc();
        rst = 1'b0; mem_done = 1'b1;
        #1;
        check_quiet("d5_post_rst");
        cyc();
        mem_done = 1'b0;
        #1;
        check_quiet("d5_post_rst2");
        cyc();
        set_req(0, 1'b0, 1'b1, 32'h35, 32'h0);
        #1;
        check("d5_gnt_b", 64'(gnt), 64'b01);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_done = 1'b1; mem_rdata = memf(32'h34 + i);
            #1;
            check("d5_addr_b", 64'(mem_addr), 64'(32'h34 + i));
            check("d5_done_b", 64'(done), (i == 3) ? 64'b01 : 64'b00);
        end
        cyc();
        req[0] = 1'b0; mem_done = 1'b0;

        // request dropped while the access is in progress
        cyc();
        set_req(0, 1'b0, 1'b0, 32'h77, 32'h0);
        #1;
        check("d6_gnt", 64'(gnt), 64'b01);
        cyc();
        req[0] = 1'b0;
        #1;
        check("d6_rden", 64'(mem_rd_en), 64'd1);
        cyc();
        mem_done = 1'b1; mem_rdata = memf(32'h77);
        #1;
        check("d6_rv", 64'(rvalid), 64'b01);
        check("d6_rd", 64'(rdata[0]), 64'(memf(32'h77)));
        check("d6_done", 64'(done), 64'b01);
        cyc();
        mem_done = 1'b0;
        #1;
        check_quiet("d6_after");

        // randomized traffic against the transaction model
        do_reset();
        m_busy = 0; m_last = 1; m_fin = 2'b00; m_own = 0;
        m_we = 1'b0; m_wd = '0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            for (int n = 0; n < 2; n++) begin
                if (m_fin[n]) req[n] = 1'b0;
                if (!req[n] && $urandom_range(0, 3) == 0)
                    set_req(n, 1'($urandom), 1'($urandom),
                            ($urandom_range(0, 7) == 0) ? $urandom
                                                        : ($urandom & 32'hFFF),
                            $urandom);
            end
            m_fin = 2'b00;
            if (mem_rd_en || mem_wr_en)
                mem_done = ($urandom_range(0, 2) == 0);
            else
                mem_done = ($urandom_range(0, 9) == 0);
            mem_rdata = mem_done ? memf(mem_addr) : $urandom;
            #1;
            e_gnt = 2'b00; e_rv = 2'b00; e_dn = 2'b00;
            e_rd[0] = '0; e_rd[1] = '0;
            if (m_busy == 0) begin
                check("r_idle_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
                if (req != 2'b00) begin
                    w = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                    e_gnt[w] = 1'b1;
                    m_last = w;
                    m_own = w;
                    m_we = we[w];
                    m_wd = wdata[w];
                    m_q.delete();
                    if (we[w] || !burst[w]) begin
                        m_q.push_back(addr[w]);
                    end else begin
                        base = {addr[w][31:2], 2'b00};
                        for (int k = 0; k < 4; k++) m_q.push_back(base + k);
                    end
                    m_busy = 1;
                end
            end else begin
                check("r_wr_en", 64'(mem_wr_en), 64'(m_we));
                check("r_rd_en", 64'(mem_rd_en), 64'(!m_we));
                check("r_addr", 64'(mem_addr), 64'(m_q[0]));
                if (m_we) check("r_wdata", 64'(mem_wdata), 64'(m_wd));
                if (mem_done) begin
                    if (!m_we) begin
                        e_rv[m_own] = 1'b1;
                        e_rd[m_own] = memf(m_q[0]);
                    end
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        e_dn[m_own] = 1'b1;
                        m_fin[m_own] = 1'b1;
                        m_busy = 0;
                    end
                end
            end
            check("r_gnt", 64'(gnt), 64'(e_gnt));
            check("r_rvalid", 64'(rvalid), 64'(e_rv));
            check("r_done", 64'(done), 64'(e_dn));
            check("r_rdata0", 64'(rdata[0]), 64'(e_rd[0]));
            check("r_rdata1", 64'(rdata[1]), 64'(e_rd[1]));
        end

        $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the data-cache controller (requester 0) and the instruction-cache refill engine (requester 1). It accepts word writes and single-word or block reads, serialises them onto the memory's enable/done handshake, and returns read words and a completion pulse to the winning requester. It sits between the cache controllers and the data memory, in place of their direct `rd_en_dm`/`wr_en_dm`/`done` connection.

## Interface
- ADDR_W, 32, word-address width
- DATA_W, 32, data word width
- BLOCK_WORDS, 4, words per block read (power of two, >= 1)
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- rN_req  in  1  request from requester N (N = 0, 1); held with its fields stable until rN_done
- rN_we  in  1  1 = single-word write, 0 = read
- rN_burst  in  1  read only: 1 = BLOCK_WORDS-word block read, 0 = single word; ignored when rN_we = 1
- rN_addr  in  ADDR_W  word address
- rN_wdata  in  DATA_W  write data
- rN_gnt  out  1  one-cycle pulse: request accepted
- rN_rvalid  out  1  one-cycle pulse per returned read word
- rN_rdata  out  DATA_W  read word, valid with rN_rvalid
- rN_done  out  1  one-cycle pulse: transaction complete
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_done
- mem_done  in  1  one-cycle pulse: access at current mem_addr complete

## Operation
- States: IDLE and ACCESS. Registers:
  - owner (1 bit)
  - last_winner: reset value 1, so requester 0 wins the first tie
  - we_q, burst_q
  - base_q: ADDR_W bits
  - wdata_q
  - cnt: log2(BLOCK_WORDS) bits, minimum 1
- IDLE, no request: stay in IDLE.
- IDLE, request present: pick a winner.
  - Only one rN_req high: that requester wins.
  - Both high: the requester that is not last_winner wins (round-robin).
  - In the same cycle:
    - Pulse the winner's rN_gnt.
    - Latch owner, we, burst and wdata.
    - Latch base_q = rN_addr. For a burst read, the low log2(BLOCK_WORDS) bits are cleared (block-aligned).
    - Clear cnt and update last_winner.
    - Next state is ACCESS.
- ACCESS: mem_wr_en = we_q and mem_rd_en = !we_q, held continuously. mem_addr = base_q + cnt and mem_wdata = wdata_q.
- In ACCESS, on mem_done:
  - Read: pulse rOwner_rvalid and drive rOwner_rdata = mem_rdata in the same cycle.
  - Last word, meaning a write, a single read, or cnt = BLOCK_WORDS-1: pulse rOwner_done in the same cycle. Next state is IDLE.
  - Otherwise: cnt increments and mem_addr advances in the next cycle. Enables stay high, and the memory treats each mem_done as completing the access at the current mem_addr.
- All rN_* outputs of the non-owner stay 0.
- rN_rdata = mem_rdata when rvalid is high, else 0.
- The requester deasserts rN_req on the clock edge that ends its done cycle, unless it is issuing a new request.
- Changes on rN_req or its fields during ACCESS are ignored. The latched transaction runs to completion and done is still pulsed.
- A request that arrives while the arbiter is busy waits in IDLE for arbitration.

## Timing
- Reset, including mid-transaction:
  - Next state is IDLE; cnt = 0; last_winner = 1.
  - All outputs are 0 in the cycle after the reset edge.
  - The in-flight transfer is dropped: no done, no rvalid.
  - mem_done arriving in IDLE is ignored.
- Request seen in IDLE at cycle T:
  - gnt at T; mem enable from T+1.
  - With mem_done at T+1 (zero-wait memory), done is at T+1.
  - Each extra memory wait cycle adds one cycle.
- Burst read with mem_done every cycle from T+1:
  - rvalid at T+1 .. T+BLOCK_WORDS; done at T+BLOCK_WORDS.
  - mem_addr = base, base+1, ...
- Back-to-back: the earliest next gnt is the cycle after done, because IDLE always lasts at least one cycle.
- Address arithmetic is modulo 2^ADDR_W. A burst never crosses a block boundary because the base is aligned.

## Test plan
- Single read, requester 0 only, r0_addr=0x10, mem_done at T+1 with mem_rdata=0xDEADBEEF -> r0_gnt at T; mem_rd_en and mem_addr=0x10 at T+1; r0_rvalid, r0_rdata=0xDEADBEEF and r0_done at T+1; r1_* all 0.
- Burst read, requester 1, r1_addr=0x23, BLOCK_WORDS=4, mem_done every cycle -> mem_addr 0x20, 0x21, 0x22, 0x23 over T+1..T+4; four r1_rvalid pulses; r1_done at T+4 only.
- Both request in the same cycle after reset, each doing a write with 2 wait cycles -> requester 0 is granted first, done at T+3; requester 1 is granted at T+4; on the next simultaneous request requester 0 wins again.
- Write, r0_addr=0x44, r0_wdata=0x12345678, mem_done delayed 5 cycles -> mem_wr_en, mem_addr and mem_wdata are stable for 5 cycles; r0_done coincides with mem_done; no r0_rvalid.
- rst asserted in the middle of a burst after 2 words -> outputs are 0 next cycle; no done; a later mem_done is ignored; a new request after reset starts at cnt=0.
- r0_req dropped mid-transaction -> transaction completes and r0_done is still pulsed.
